// File: rtl/mat_pkg.sv
// Shared definitions for the matrix unit: widths, word addressing and write FSM states.
package mat_pkg;

    localparam int DIM_WIDTH  = 3;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_DIM    = 7;
    localparam int ADDR_WIDTH = 2 * DIM_WIDTH + 1;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_LOAD = 1'b1
    } wstate_t;

    function automatic logic [ADDR_WIDTH-1:0] mat_addr(
        input logic                 slot,
        input logic [DIM_WIDTH-1:0] row,
        input logic [DIM_WIDTH-1:0] col
    );
        return {slot, row, col};
    endfunction

endpackage

// File: rtl/mat_storage_ram.sv
// Simple dual-port word store: synchronous write, registered read, contents never reset.
module mat_storage_ram #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mat_storage.sv
// Two-slot matrix store: row-major load stream in, one-element-per-request read responder out.
module mat_storage import mat_pkg::*; #(
    parameter int DIM_WIDTH  = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_start,
    input  logic                  wr_slot,
    input  logic [DIM_WIDTH-1:0]  wr_m,
    input  logic [DIM_WIDTH-1:0]  wr_n,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_elem,
    input  logic                  wr_abort,
    output logic                  wr_ready,
    output logic                  wr_done,
    output logic                  wr_error,
    input  logic                  rd_en,
    input  logic                  rd_slot_idx,
    input  logic [DIM_WIDTH-1:0]  rd_row_idx,
    input  logic [DIM_WIDTH-1:0]  rd_col_idx,
    output logic [DATA_WIDTH-1:0] rd_elem,
    output logic                  rd_elem_valid,
    output logic                  rd_oob,
    output logic [1:0]            slot_valid,
    output logic [DIM_WIDTH-1:0]  slot0_m,
    output logic [DIM_WIDTH-1:0]  slot0_n,
    output logic [DIM_WIDTH-1:0]  slot1_m,
    output logic [DIM_WIDTH-1:0]  slot1_n
);

    localparam int AW = 2 * DIM_WIDTH + 1;

    wstate_t               state;
    logic                  load_slot;
    logic [DIM_WIDTH-1:0]  load_m;
    logic [DIM_WIDTH-1:0]  load_n;
    logic [DIM_WIDTH-1:0]  row_cnt;
    logic [DIM_WIDTH-1:0]  col_cnt;
    logic [DIM_WIDTH-1:0]  dim_m [2];
    logic [DIM_WIDTH-1:0]  dim_n [2];
    logic [1:0]            valid_q;
    logic                  ready_q;
    logic                  done_q;
    logic                  error_q;

    logic                  accept;
    logic                  last_col;
    logic                  last_row;

    logic                  rd_bad;
    logic                  rd_valid_q;
    logic                  rd_oob_q;
    logic                  rd_has_data;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [AW-1:0]         waddr;
    logic [AW-1:0]         raddr;

    // Abort wins over a coincident element, so the element is never committed.
    assign accept   = (state == W_LOAD) && wr_valid && !wr_abort;
    assign last_col = (col_cnt == load_n - DIM_WIDTH'(1));
    assign last_row = (row_cnt == load_m - DIM_WIDTH'(1));
    assign waddr    = {load_slot, row_cnt, col_cnt};
    assign raddr    = {rd_slot_idx, rd_row_idx, rd_col_idx};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= W_IDLE;
            load_slot <= 1'b0;
            load_m    <= '0;
            load_n    <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            dim_m[0]  <= '0;
            dim_m[1]  <= '0;
            dim_n[0]  <= '0;
            dim_n[1]  <= '0;
            valid_q   <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state)
                W_IDLE: begin
                    if (wr_start) begin
                        if ((wr_m != '0) && (wr_n != '0)) begin
                            load_slot        <= wr_slot;
                            load_m           <= wr_m;
                            load_n           <= wr_n;
                            row_cnt          <= '0;
                            col_cnt          <= '0;
                            valid_q[wr_slot] <= 1'b0;
                            ready_q          <= 1'b1;
                            state            <= W_LOAD;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                W_LOAD: begin
                    if (wr_abort) begin
                        ready_q <= 1'b0;
                        state   <= W_IDLE;
                    end else if (wr_valid) begin
                        if (last_col && last_row) begin
                            valid_q[load_slot] <= 1'b1;
                            dim_m[load_slot]   <= load_m;
                            dim_n[load_slot]   <= load_n;
                            done_q             <= 1'b1;
                            ready_q            <= 1'b0;
                            state              <= W_IDLE;
                        end else if (last_col) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + DIM_WIDTH'(1);
                        end else begin
                            col_cnt <= col_cnt + DIM_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state   <= W_IDLE;
                end
            endcase
        end
    end

    // A slot under load is already invalid, so this check also blocks same-word read/write.
    assign rd_bad = !valid_q[rd_slot_idx]
                 || (rd_row_idx >= dim_m[rd_slot_idx])
                 || (rd_col_idx >= dim_n[rd_slot_idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q  <= 1'b0;
            rd_oob_q    <= 1'b0;
            rd_has_data <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_oob_q    <= rd_bad;
                rd_has_data <= 1'b1;
            end
        end
    end

    mat_storage_ram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (waddr),
        .wdata (wr_elem),
        .re    (rd_en && !rd_bad),
        .raddr (raddr),
        .rdata (ram_q)
    );

    // RAM output is unreset; gating keeps rd_elem at 0 after reset and for rejected reads.
    assign rd_elem       = (rd_has_data && !rd_oob_q) ? ram_q : '0;
    assign rd_elem_valid = rd_valid_q;
    assign rd_oob        = rd_valid_q && rd_oob_q;

    assign wr_ready   = ready_q;
    assign wr_done    = done_q;
    assign wr_error   = error_q;
    assign slot_valid = valid_q;
    assign slot0_m    = dim_m[0];
    assign slot0_n    = dim_n[0];
    assign slot1_m    = dim_m[1];
    assign slot1_n    = dim_n[1];

endmodule

// File: tb/tb_mat_storage.sv
// Self-checking bench for mat_storage against an array-based model of the two-slot store.
module tb_mat_storage;

    localparam int DW = 3;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_start;
    logic          wr_slot;
    logic [DW-1:0] wr_m;
    logic [DW-1:0] wr_n;
    logic          wr_valid;
    logic [EW-1:0] wr_elem;
    logic          wr_abort;
    logic          wr_ready;
    logic          wr_done;
    logic          wr_error;
    logic          rd_en;
    logic          rd_slot_idx;
    logic [DW-1:0] rd_row_idx;
    logic [DW-1:0] rd_col_idx;
    logic [EW-1:0] rd_elem;
    logic          rd_elem_valid;
    logic          rd_oob;
    logic [1:0]    slot_valid;
    logic [DW-1:0] slot0_m;
    logic [DW-1:0] slot0_n;
    logic [DW-1:0] slot1_m;
    logic [DW-1:0] slot1_n;

    always #5 clk = ~clk;

    mat_storage #(
        .DIM_WIDTH  (DW),
        .DATA_WIDTH (EW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_start      (wr_start),
        .wr_slot       (wr_slot),
        .wr_m          (wr_m),
        .wr_n          (wr_n),
        .wr_valid      (wr_valid),
        .wr_elem       (wr_elem),
        .wr_abort      (wr_abort),
        .wr_ready      (wr_ready),
        .wr_done       (wr_done),
        .wr_error      (wr_error),
        .rd_en         (rd_en),
        .rd_slot_idx   (rd_slot_idx),
        .rd_row_idx    (rd_row_idx),
        .rd_col_idx    (rd_col_idx),
        .rd_elem       (rd_elem),
        .rd_elem_valid (rd_elem_valid),
        .rd_oob        (rd_oob),
        .slot_valid    (slot_valid),
        .slot0_m       (slot0_m),
        .slot0_n       (slot0_n),
        .slot1_m       (slot1_m),
        .slot1_n       (slot1_n)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: matrices as plain 2-D arrays, a load tracked by element count.
    int mem_m [2][8][8];
    bit valid_m [2];
    int m_m [2];
    int n_m [2];
    bit loading;
    int ld_slot, ld_m, ld_n, ld_k;
    int e_rd_elem;
    bit e_rd_valid, e_rd_oob, e_done, e_error;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("wr_ready",      32'(wr_ready),      32'(loading));
        chk("wr_done",       32'(wr_done),       32'(e_done));
        chk("wr_error",      32'(wr_error),      32'(e_error));
        chk("slot_valid",    32'(slot_valid),    {30'd0, valid_m[1], valid_m[0]});
        chk("slot0_m",       32'(slot0_m),       32'(m_m[0]));
        chk("slot0_n",       32'(slot0_n),       32'(n_m[0]));
        chk("slot1_m",       32'(slot1_m),       32'(m_m[1]));
        chk("slot1_n",       32'(slot1_n),       32'(n_m[1]));
        chk("rd_elem_valid", 32'(rd_elem_valid), 32'(e_rd_valid));
        chk("rd_oob",        32'(rd_oob),        32'(e_rd_oob));
        chk("rd_elem",       32'(rd_elem),       32'(e_rd_elem));
    endtask

    // Apply the currently driven inputs to the model, clock once, compare, then drop request strobes.
    task automatic cycle();
        bit oob;
        int s;
        s = int'(rd_slot_idx);
        e_rd_valid = rd_en;
        e_rd_oob   = 1'b0;
        if (rd_en) begin
            oob = !valid_m[s] || (int'(rd_row_idx) >= m_m[s]) || (int'(rd_col_idx) >= n_m[s]);
            e_rd_oob  = oob;
            e_rd_elem = oob ? 0 : mem_m[s][rd_row_idx][rd_col_idx];
        end
        e_done  = 1'b0;
        e_error = 1'b0;
        if (!loading) begin
            if (wr_start) begin
                if (wr_m != 0 && wr_n != 0) begin
                    loading = 1'b1;
                    ld_slot = int'(wr_slot);
                    ld_m = int'(wr_m);
                    ld_n = int'(wr_n);
                    ld_k = 0;
                    valid_m[ld_slot] = 1'b0;
                end else begin
                    e_error = 1'b1;
                end
            end
        end else if (wr_abort) begin
            loading = 1'b0;
        end else if (wr_valid) begin
            mem_m[ld_slot][ld_k / ld_n][ld_k % ld_n] = int'(wr_elem);
            ld_k++;
            if (ld_k == ld_m * ld_n) begin
                valid_m[ld_slot] = 1'b1;
                m_m[ld_slot] = ld_m;
                n_m[ld_slot] = ld_n;
                e_done  = 1'b1;
                loading = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_all();
        wr_start = 1'b0;
        wr_valid = 1'b0;
        wr_abort = 1'b0;
        rd_en    = 1'b0;
    endtask

    task automatic model_reset();
        loading = 1'b0;
        for (int s = 0; s < 2; s++) begin
            valid_m[s] = 1'b0;
            m_m[s] = 0;
            n_m[s] = 0;
        end
        e_rd_elem = 0; e_rd_valid = 1'b0; e_rd_oob = 1'b0;
        e_done = 1'b0; e_error = 1'b0;
    endtask

    task automatic rd(input int s, input int r, input int c);
        rd_en = 1'b1;
        rd_slot_idx = 1'(s);
        rd_row_idx  = 3'(r);
        rd_col_idx  = 3'(c);
        cycle();
    endtask

    // rd_sel: -1 no reads, 0/1 read that slot, 2 read a random slot; coordinates span 0..7.
    task automatic load_matrix(input int s, input int m, input int n, input int gap_pct,
                               input int rd_sel, input bit seq, input bit noise);
        wr_start = 1'b1;
        wr_slot  = 1'(s);
        wr_m     = 3'(m);
        wr_n     = 3'(n);
        cycle();
        for (int i = 0; i < 400 && loading; i++) begin
            if ($urandom_range(0, 99) >= gap_pct) begin
                wr_valid = 1'b1;
                wr_elem  = seq ? 8'(ld_k + 1) : 8'($urandom);
            end
            if (noise && $urandom_range(0, 5) == 0) begin
                wr_start = 1'b1;
                wr_slot  = 1'($urandom);
                wr_m     = 3'($urandom);
                wr_n     = 3'($urandom);
            end
            if (rd_sel >= 0) begin
                rd_en       = 1'b1;
                rd_slot_idx = (rd_sel == 2) ? 1'($urandom) : 1'(rd_sel);
                rd_row_idx  = 3'($urandom);
                rd_col_idx  = 3'($urandom);
            end
            cycle();
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_start = 1'b0; wr_slot = 1'b0; wr_m = '0; wr_n = '0;
        wr_valid = 1'b0; wr_elem = '0; wr_abort = 1'b0;
        rd_en = 1'b0; rd_slot_idx = 1'b0; rd_row_idx = '0; rd_col_idx = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // 2x3 load of 1..6, then a single read of (1,2)
        load_matrix(0, 2, 3, 0, -1, 1'b1, 1'b0);
        rd(0, 1, 2);
        chk("read_1_2", 32'(rd_elem), 32'd6);

        // back-to-back reads of every element in row-major order
        for (int k = 0; k < 6; k++) begin
            rd(0, k / 3, k % 3);
            chk("b2b_order", 32'(rd_elem), 32'(k + 1));
        end

        // zero-dimension start rejected; never-loaded slot reads out of range
        wr_start = 1'b1; wr_slot = 1'b1; wr_m = 3'd0; wr_n = 3'd3;
        cycle();
        wr_start = 1'b1; wr_slot = 1'b0; wr_m = 3'd4; wr_n = 3'd0;
        cycle();
        rd(1, 0, 0);
        chk("unloaded_oob", 32'(rd_oob), 32'd1);

        // slot 1 at 3x3 with gaps while slot 0 is read every cycle, then slot 1 polled
        load_matrix(1, 3, 3, 40, 0, 1'b0, 1'b1);
        load_matrix(1, 3, 3, 30, 1, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) rd(1, k / 3, k % 3);
        rd(1, 3, 0);
        rd(1, 0, 3);

        // reload slot 0, abort after two elements
        wr_start = 1'b1; wr_slot = 1'b0; wr_m = 3'd2; wr_n = 3'd2;
        cycle();
        for (int k = 0; k < 2; k++) begin
            wr_valid = 1'b1; wr_elem = 8'($urandom);
            cycle();
        end
        wr_abort = 1'b1;
        cycle();
        rd(0, 0, 0);
        chk("abort_oob", 32'(rd_oob), 32'd1);

        // abort coinciding with the final element
        wr_start = 1'b1; wr_slot = 1'b1; wr_m = 3'd1; wr_n = 3'd2;
        cycle();
        wr_valid = 1'b1; wr_elem = 8'h11;
        cycle();
        wr_valid = 1'b1; wr_elem = 8'h22; wr_abort = 1'b1;
        cycle();
        rd(1, 0, 0);

        // maximum dimensions, then a new start on the cycle right after completion
        load_matrix(0, 7, 7, 20, 2, 1'b0, 1'b1);
        load_matrix(1, 1, 1, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) rd(0, $urandom_range(0, 7), $urandom_range(0, 7));

        // reset in the middle of a load
        wr_start = 1'b1; wr_slot = 1'b1; wr_m = 3'd3; wr_n = 3'd2;
        cycle();
        wr_valid = 1'b1; wr_elem = 8'h5a;
        rd_en = 1'b1; rd_slot_idx = 1'b0; rd_row_idx = 3'd0; rd_col_idx = 3'd0;
        cycle();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_matrix(1, 2, 2, 0, 2, 1'b0, 1'b0);

        // randomized loads and reads across both slots
        for (int t = 0; t < 6; t++) begin
            load_matrix($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 50), 2, 1'b0, 1'b1);
            for (int k = 0; k < 8; k++) rd($urandom_range(0, 1), $urandom_range(0, 7),
                                           $urandom_range(0, 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mat_storage.md
# mat_storage

Two-slot matrix store. It is the responder on the matrix-unit read interface: `rd_en` with slot/row/col in, `rd_elem`/`rd_elem_valid` back. It also takes a row-major write stream that loads a matrix into a slot and publishes per-slot valid flags and dimensions. It sits between the input/loader logic and every matrix operator (add, transpose, scalar-multiply), which read it one element at a time.

## Interface
Parameters:
- `DIM_WIDTH`, 3: row/col index width; max dimension 7.
- `DATA_WIDTH`, 8: element width.

Ports (reset is asynchronous and active-high; one clock):
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  asynchronous reset, active-high.
- `wr_start`  in  1  begin loading a matrix; sampled only in W_IDLE.
- `wr_slot`  in  1  target slot; sampled with `wr_start`.
- `wr_m`, `wr_n`  in  DIM_WIDTH each  rows and cols; sampled with `wr_start`.
- `wr_valid`  in  1  `wr_elem` is valid.
- `wr_elem`  in  DATA_WIDTH  element, row-major order.
- `wr_abort`  in  1  abandon the current load.
- `wr_ready`  out  1  store accepts `wr_elem`.
- `wr_done`  out  1  one-cycle pulse; load complete.
- `wr_error`  out  1  one-cycle pulse; `wr_start` rejected.
- `rd_en`  in  1  read request.
- `rd_slot_idx`  in  1  read slot.
- `rd_row_idx`, `rd_col_idx`  in  DIM_WIDTH each  read coordinates.
- `rd_elem`  out  DATA_WIDTH  read data.
- `rd_elem_valid`  out  1  one-cycle pulse; `rd_elem` is valid.
- `rd_oob`  out  1  pulse together with `rd_elem_valid`; the request was invalid.
- `slot_valid`  out  2  bit s is 1 when slot s holds a complete matrix.
- `slot0_m`, `slot0_n`, `slot1_m`, `slot1_n`  out  DIM_WIDTH each  stored dimensions.

## Operation
- Storage: 2 slots × 64 words. Word address = {slot, row, col}. Word contents are not reset.
- Write FSM, W_IDLE:
  - `wr_start` with `wr_m`≠0 and `wr_n`≠0: latch slot and dims, clear row/col counters, clear `slot_valid[wr_slot]`, go to W_LOAD.
  - `wr_start` with a zero dimension: pulse `wr_error`, stay in W_IDLE, change nothing.
- Write FSM, W_LOAD:
  - `wr_ready`=1 throughout.
  - Each `wr_valid`&&`wr_ready` cycle writes `wr_elem` at (row,col). col increments; at n-1, col wraps to 0 and row increments.
  - The element at (m-1,n-1) is the last. After it: set `slot_valid`, update that slot's m/n outputs, pulse `wr_done`, return to W_IDLE.
  - `wr_start` is ignored in W_LOAD.
  - `wr_abort` returns to W_IDLE with no pulse; the slot stays invalid.
  - `wr_abort` in the same cycle as the last element: abort wins.
- Read:
  - Each `rd_en` cycle produces exactly one `rd_elem_valid` pulse; requests may issue every cycle.
  - The request is out-of-range when the slot is invalid, row ≥ stored m, or col ≥ stored n. Out-of-range reads return `rd_elem`=0 with `rd_oob`=1.
  - Reading the slot being loaded is out-of-range, because that slot is invalid.
- Reading one slot while loading the other is legal and independent.

## Timing
- Reset values: `wr_ready`, `wr_done`, `wr_error`, `rd_elem`, `rd_elem_valid`, `rd_oob`, `slot_valid`, and all dimension outputs are 0. FSM is in W_IDLE.
- Reset mid-load: both slots become invalid; the FSM returns to W_IDLE.
- Read latency is 1: `rd_en` at edge T gives `rd_elem`/`rd_elem_valid`/`rd_oob` in the cycle after T. `rd_elem` holds its value until the next read.
- Write start: `wr_start` accepted at edge T makes `wr_ready`=1 from T+1. `slot_valid[s]` is 0 from T+1.
- Write completion: with the last element accepted at edge L:
  - `wr_ready`=0, `wr_done`=1, `slot_valid[s]`=1 and dimensions updated, all in cycle L+1.
  - A new `wr_start` is accepted at edge L+1.
- `wr_error` appears in the cycle after the rejected `wr_start`.
- Minimum load time is m·n+1 cycles from start.
- Same-cycle read and write to the same word cannot occur, because the slot being loaded is invalid.

## Structure
- Shared package `mat_pkg`:
  - `DIM_WIDTH`, `DATA_WIDTH`, and `MAX_DIM`=7.
  - Address width 2·DIM_WIDTH+1.
  - A `mat_addr(slot,row,col)` function.
  - Write FSM state encodings W_IDLE and W_LOAD.
- Sub-module `mat_storage_ram`: simple dual-port RAM, 128×DATA_WIDTH. Synchronous write, registered read, no reset on contents.
- The top level holds the write FSM, counters, metadata registers, and range-check pipeline register.

## Test plan
- Load slot 0, 2×3, values 1..6, one per cycle. Then read (1,2). Expect `wr_done` one cycle after the 6th element, `slot_valid`=01, m=2, n=3, `rd_elem`=6 one cycle after `rd_en`, `rd_oob`=0.
- Read back-to-back for 6 cycles covering all elements. Expect 6 consecutive `rd_elem_valid` pulses, in order 1..6.
- `wr_start` with `wr_m`=0. Expect a `wr_error` pulse and no change to `slot_valid`. Read slot 1 (never loaded): expect `rd_elem`=0, `rd_oob`=1.
- Load slot 1 at 3×3 with gaps in `wr_valid`, while reading slot 0 every cycle. Slot 0 reads stay correct. Slot 1 reads return `rd_oob`=1 until `wr_done`.
- Reload slot 0 and assert `wr_abort` after 2 elements. Expect `slot_valid[0]`=0 and reads of slot 0 (0,0) to return `rd_oob`=1.
- Assert `rst` mid-load. Expect all outputs 0 on the same edge, `slot_valid`=00, and `wr_start` accepted on the first cycle after release.
